// File: rtl/fetch_pkg.sv
// Shared opcodes, BHT counter type and the saturating counter update used by
// the fetch stage.
package fetch_pkg;

    localparam logic [5:0]  OP_BEQ   = 6'h04;
    localparam logic [5:0]  OP_BNE   = 6'h05;
    localparam logic [5:0]  OP_J     = 6'h02;
    localparam logic [31:0] NOP_WORD = 32'h0;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t BHT_WNT = 2'b01;

    // 2-bit saturating counter step: 11 and 00 are sticky at their ends.
    function automatic bht_ctr_t bht_next(bht_ctr_t c, logic taken);
        if (taken) return (c == 2'b11) ? c : c + 2'b01;
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/fetch_predict_stage_bht.sv
// Untagged 2-bit saturating branch history table: one combinational read port,
// one synchronous training port.
module bht_2bit
    import fetch_pkg::*;
#(
    parameter int IDX = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [IDX-1:0] rd_idx_i,
    output logic [1:0]     rd_ctr_o,
    input  logic           upd_valid_i,
    input  logic [IDX-1:0] upd_idx_i,
    input  logic           upd_taken_i
);

    localparam int DEPTH = 2 ** IDX;

    logic [DEPTH-1:0][1:0] ctr_q, ctr_d;

    always_comb begin
        ctr_d = ctr_q;
        if (upd_valid_i)
            ctr_d[upd_idx_i] = bht_next(ctr_q[upd_idx_i], upd_taken_i);
    end

    // Read sees the registered value, so a same-cycle update is not forwarded.
    assign rd_ctr_o = ctr_q[rd_idx_i];

    always_ff @(posedge clk) begin
        if (!reset) ctr_q <= {DEPTH{BHT_WNT}};
        else        ctr_q <= ctr_d;
    end

endmodule

// File: rtl/fetch_predict_stage.sv
// Instruction fetch: PC register, BHT-based branch prediction, next-PC
// selection and the IF/ID pipeline register.
module fetch_predict_stage
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH = 5,
    parameter int BHT_IDX  = 4
) (
    input  logic                clk,
    input  logic                reset,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_data,
    input  logic                if_id_write,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic                upd_valid,
    input  logic [PC_WIDTH-1:0] upd_pc,
    input  logic                upd_taken,
    output logic [31:0]         instr_D,
    output logic [PC_WIDTH-1:0] pc_D,
    output logic [PC_WIDTH-1:0] pc_plus1_D,
    output logic                prediction_D,
    output logic                valid_D
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] pc_plus1, imm_ext, target;
    logic [5:0]          opcode;
    logic                is_cond, is_jump, pred_taken;
    logic [1:0]          bht_ctr;
    logic                unused_imem;

    assign imem_addr   = pc_q;
    assign opcode      = imem_data[31:26];
    assign is_cond     = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign is_jump     = (opcode == OP_J);
    assign unused_imem = ^imem_data[25:16];

    // Sign-extend then truncate; the add wraps modulo 2**PC_WIDTH.
    assign imm_ext  = PC_WIDTH'($signed(imem_data[15:0]));
    assign pc_plus1 = pc_q + PC_ONE;
    assign target   = pc_plus1 + imm_ext;

    bht_2bit #(.IDX(BHT_IDX)) u_bht (
        .clk         (clk),
        .reset       (reset),
        .rd_idx_i    (pc_q[BHT_IDX-1:0]),
        .rd_ctr_o    (bht_ctr),
        .upd_valid_i (upd_valid),
        .upd_idx_i   (upd_pc[BHT_IDX-1:0]),
        .upd_taken_i (upd_taken)
    );

    assign pred_taken = is_jump | (is_cond & bht_ctr[1]);

    always_comb begin
        pc_d = pc_plus1;
        if (redirect_valid)   pc_d = redirect_pc;
        else if (!if_id_write) pc_d = pc_q;
        else if (pred_taken)  pc_d = target;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q         <= '0;
            instr_D      <= NOP_WORD;
            pc_D         <= '0;
            pc_plus1_D   <= '0;
            prediction_D <= 1'b0;
            valid_D      <= 1'b0;
        end else begin
            pc_q <= pc_d;
            // A redirect flushes IF/ID even while decode is stalled.
            if (redirect_valid) begin
                instr_D      <= NOP_WORD;
                pc_D         <= '0;
                pc_plus1_D   <= '0;
                prediction_D <= 1'b0;
                valid_D      <= 1'b0;
            end else if (if_id_write) begin
                instr_D      <= imem_data;
                pc_D         <= pc_q;
                pc_plus1_D   <= pc_plus1;
                prediction_D <= pred_taken;
                valid_D      <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fetch_predict_stage.md
Name: fetch_predict_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline. Holds the PC, reads instruction memory, predicts branches with a 2-bit saturating branch history table (BHT), and drives the IF/ID pipeline register.
- Downstream consumer is the decode stage.
- Takes stall from the hazard detection unit, redirects from EX (branch mispredict, JR), and BHT training from EX.

Parameters:
- PC_WIDTH, 5, PC / instruction-memory address width in words.
- BHT_IDX, 4, BHT index bits; BHT has 2**BHT_IDX entries indexed by pc[BHT_IDX-1:0].

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- imem_addr  out  PC_WIDTH  instruction memory address (= current PC); memory is combinational-read.
- imem_data  in  32  instruction word at imem_addr.
- if_id_write  in  1  1 = advance; 0 = stall (hold PC and IF/ID).
- redirect_valid  in  1  EX mispredict or JR: fetch from redirect_pc, flush IF/ID.
- redirect_pc  in  PC_WIDTH  corrected next PC.
- upd_valid  in  1  train BHT this cycle (resolved conditional branch).
- upd_pc  in  PC_WIDTH  PC of resolved branch.
- upd_taken  in  1  actual branch outcome.
- instr_D  out  32  IF/ID instruction.
- pc_D  out  PC_WIDTH  IF/ID PC.
- pc_plus1_D  out  PC_WIDTH  IF/ID PC+1, used for recovery on a wrongly predicted taken branch.
- prediction_D  out  1  IF/ID predicted-taken flag.
- valid_D  out  1  0 = bubble.

Behaviour:
- Reset (reset==0 at posedge) dominates all other inputs, including upd_valid.
  - pc <= 0.
  - instr_D, pc_D, pc_plus1_D, prediction_D, valid_D <= 0.
  - Every BHT entry <= 2'b01 (weakly not-taken).
- Decode of imem_data, combinational:
  - is_cond = opcode is OP_BEQ or OP_BNE.
  - is_jump = opcode is OP_J.
  - Opcode is imem_data[31:26].
  - target = pc + 1 + sign-extended imem_data[15:0], truncated to PC_WIDTH.
- Prediction: pred_taken = is_jump | (is_cond & bht[pc[BHT_IDX-1:0]][1]).
- Next-PC priority, highest first:
  - redirect_valid: redirect_pc.
  - !if_id_write: pc (hold).
  - pred_taken: target.
  - otherwise: pc+1.
  - Arithmetic wraps modulo 2**PC_WIDTH (pc 31 + 1 -> 0).
- IF/ID register:
  - redirect_valid: load bubble (instr_D=0, valid_D=0, prediction_D=0; pc_D/pc_plus1_D=0). Redirect overrides stall.
  - else !if_id_write: hold all fields.
  - else load instr_D=imem_data, pc_D=pc, pc_plus1_D=pc+1, prediction_D=pred_taken, valid_D=1.
- BHT update, on upd_valid at posedge, entry upd_pc[BHT_IDX-1:0]:
  - upd_taken=1: saturating increment; 11 stays 11.
  - upd_taken=0: saturating decrement; 00 stays 00.
- BHT timing and conflicts:
  - Update proceeds regardless of stall or redirect.
  - If the same index is read and updated in one cycle, the prediction uses the pre-update value.
  - Aliasing is accepted: no tags.
- Latency:
  - An instruction at PC appears on instr_D one cycle after PC is presented.
  - A redirect takes effect on imem_addr the cycle after redirect_valid is asserted.
  - One bubble per redirect.

Decomposition:
- Package fetch_pkg holds OP_BEQ=6'h04, OP_BNE=6'h05, OP_J=6'h02, NOP word 32'h0, and typedef bht_ctr_t (logic [1:0]) with BHT_WNT=2'b01.
- One sub-module: bht_2bit, holding the counter array, read port, and saturating update port; reset to BHT_WNT.
- PC, next-PC mux, and IF/ID register stay in fetch_predict_stage.

Test Plan:
- Reset then sequential fetch: hold reset=0 for 2 cycles, release, memory of ALU ops. Required: imem_addr = 0,1,2,3 on successive cycles; instr_D lags one cycle; valid_D=1 from the second cycle after release; all outputs 0 during reset.
- Stall: deassert if_id_write for 3 cycles at pc=4. Required: imem_addr holds 4; instr_D/pc_D hold the pc=3 contents; fetch resumes at 5 afterwards.
- Branch training: BEQ at pc=6 with imm=+3 is predicted not-taken (prediction_D=0, next imem_addr 7). Apply upd_valid/upd_pc=6/upd_taken=1 once, then refetch pc=6. Required: prediction_D=1 and next imem_addr=10. A further 3 taken updates then 1 not-taken leaves the prediction taken (saturates at 11, drops to 10).
- Redirect during stall: redirect_valid=1, redirect_pc=20, if_id_write=0 together. Required: next imem_addr=20; valid_D=0 and instr_D=0 next cycle.
- Wrap and jump: OP_J at pc=31 with imm=-5. Required: target = (31+1-5) mod 32 = 27; prediction_D=1. A plain op at pc=31 gives next imem_addr 0.
- Reset mid-operation plus aliasing: train pc=3 to taken, then fetch BEQ at pc=19. Required: predicted taken via the shared entry. Assert reset with upd_valid=1 in the same cycle. Required: all BHT entries return to 01, pc=0, upd_valid ignored.
